// File: rtl/frame_scene_ctrl.sv
// Frame-synchronous scene controller. It stages one physics update and commits it
// to the pixel_gen-facing registers only during vertical blanking, deriving camera_y.
module frame_scene_ctrl #(
  parameter int PHY_WIDTH       = 14,
  parameter int OBSTACLE_NUM    = 10,
  parameter int BLOCK_LEN_WIDTH = 4,
  parameter int BLOCK_WIDTH     = 480,
  parameter int CAM_WIDTH       = 5,
  parameter int SCREEN_WIDTH    = 10,
  parameter int V_ACTIVE        = 480
) (
  input  logic                                    sys_clk,
  input  logic                                    sys_rst,
  input  logic [SCREEN_WIDTH-1:0]                 y,
  input  logic                                    upd_valid,
  output logic                                    upd_ready,
  input  logic [PHY_WIDTH-1:0]                    upd_char_x,
  input  logic [PHY_WIDTH-1:0]                    upd_char_y,
  input  logic [OBSTACLE_NUM*PHY_WIDTH-1:0]       upd_obs_x,
  input  logic [OBSTACLE_NUM*PHY_WIDTH-1:0]       upd_obs_y,
  input  logic [OBSTACLE_NUM*BLOCK_LEN_WIDTH-1:0] upd_obs_len,
  output logic [PHY_WIDTH-1:0]                    char_abs_x,
  output logic [PHY_WIDTH-1:0]                    char_abs_y,
  output logic [OBSTACLE_NUM*PHY_WIDTH-1:0]       obstacle_abs_pos_x,
  output logic [OBSTACLE_NUM*PHY_WIDTH-1:0]       obstacle_abs_pos_y,
  output logic [OBSTACLE_NUM*BLOCK_LEN_WIDTH-1:0] obstacle_block_width,
  output logic [CAM_WIDTH-1:0]                    camera_y,
  output logic                                    commit_pulse,
  output logic [7:0]                              drop_cnt
);

  typedef enum logic [1:0] {IDLE, DIV, COMMIT} state_t;

  state_t                                  state, state_nxt;
  logic                                    vb_q, vb_d, vb_fall;
  logic                                    pend, done, xfer, div_step;
  logic [PHY_WIDTH-1:0]                    rem;
  logic [CAM_WIDTH-1:0]                    q;
  logic [PHY_WIDTH-1:0]                    st_char_x, st_char_y;
  logic [OBSTACLE_NUM*PHY_WIDTH-1:0]       st_obs_x, st_obs_y;
  logic [OBSTACLE_NUM*BLOCK_LEN_WIDTH-1:0] st_obs_len;

  assign upd_ready = ~pend & ~sys_rst;
  assign xfer      = upd_valid & upd_ready;
  assign vb_fall   = vb_d & ~vb_q;
  // Quotient saturates at all-ones so camera_y never wraps for very large char_y.
  assign div_step  = (rem >= PHY_WIDTH'(BLOCK_WIDTH)) && (q != '1);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (vb_q && pend && !done) state_nxt = DIV;
      DIV:     if (!div_step) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      vb_q                 <= 1'b0;
      vb_d                 <= 1'b0;
      pend                 <= 1'b0;
      done                 <= 1'b0;
      rem                  <= '0;
      q                    <= '0;
      st_char_x            <= '0;
      st_char_y            <= '0;
      st_obs_x             <= '0;
      st_obs_y             <= '0;
      st_obs_len           <= '0;
      char_abs_x           <= '0;
      char_abs_y           <= '0;
      obstacle_abs_pos_x   <= '0;
      obstacle_abs_pos_y   <= '0;
      obstacle_block_width <= '0;
      camera_y             <= '0;
      commit_pulse         <= 1'b0;
      drop_cnt             <= '0;
    end else begin
      vb_q         <= (y >= SCREEN_WIDTH'(V_ACTIVE));
      vb_d         <= vb_q;
      commit_pulse <= 1'b0;

      if (xfer) begin
        st_char_x  <= upd_char_x;
        st_char_y  <= upd_char_y;
        st_obs_x   <= upd_obs_x;
        st_obs_y   <= upd_obs_y;
        st_obs_len <= upd_obs_len;
        pend       <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (state_nxt == DIV) begin
            rem <= st_char_y;
            q   <= '0;
          end
        end
        DIV: begin
          if (div_step) begin
            rem <= rem - PHY_WIDTH'(BLOCK_WIDTH);
            q   <= q + 1'b1;
          end
        end
        COMMIT: begin
          char_abs_x           <= st_char_x;
          char_abs_y           <= st_char_y;
          obstacle_abs_pos_x   <= st_obs_x;
          obstacle_abs_pos_y   <= st_obs_y;
          obstacle_block_width <= st_obs_len;
          camera_y             <= q;
          pend                 <= 1'b0;
          commit_pulse         <= 1'b1;
        end
        default: ;
      endcase

      // A commit that overruns past the end of vblank must not block the next frame.
      if (vb_fall)                     done <= 1'b0;
      else if (state == COMMIT && vb_q) done <= 1'b1;

      if (vb_fall && !done && drop_cnt != '1) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_frame_scene_ctrl.sv
// Directed, table-driven bench for frame_scene_ctrl using compressed frames
// (20 active cycles at y=100, 50 vblank cycles at y=480).
module tb_frame_scene_ctrl;

  localparam int PW  = 14;
  localparam int ON  = 10;
  localparam int BLW = 4;
  localparam int OW  = ON*PW;
  localparam int LW  = ON*BLW;

  logic           sys_clk = 1'b0;
  logic           sys_rst;
  logic [9:0]     y;
  logic           upd_valid;
  logic           upd_ready;
  logic [PW-1:0]  upd_char_x, upd_char_y;
  logic [OW-1:0]  upd_obs_x, upd_obs_y;
  logic [LW-1:0]  upd_obs_len;
  logic [PW-1:0]  char_abs_x, char_abs_y;
  logic [OW-1:0]  obstacle_abs_pos_x, obstacle_abs_pos_y;
  logic [LW-1:0]  obstacle_block_width;
  logic [4:0]     camera_y;
  logic           commit_pulse;
  logic [7:0]     drop_cnt;

  int ntests = 0;
  int nfail  = 0;
  int pulse_cnt = 0;

  always #5 sys_clk = ~sys_clk;

  frame_scene_ctrl #(.PHY_WIDTH(PW), .OBSTACLE_NUM(ON), .BLOCK_LEN_WIDTH(BLW),
                     .BLOCK_WIDTH(480), .CAM_WIDTH(5), .SCREEN_WIDTH(10),
                     .V_ACTIVE(480)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .y(y),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_char_x(upd_char_x), .upd_char_y(upd_char_y),
    .upd_obs_x(upd_obs_x), .upd_obs_y(upd_obs_y), .upd_obs_len(upd_obs_len),
    .char_abs_x(char_abs_x), .char_abs_y(char_abs_y),
    .obstacle_abs_pos_x(obstacle_abs_pos_x), .obstacle_abs_pos_y(obstacle_abs_pos_y),
    .obstacle_block_width(obstacle_block_width),
    .camera_y(camera_y), .commit_pulse(commit_pulse), .drop_cnt(drop_cnt)
  );

  always @(negedge sys_clk) if (commit_pulse) pulse_cnt++;

  typedef struct {
    logic [PW-1:0] cx;
    logic [PW-1:0] cy;
    logic [4:0]    cam;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [OW-1:0] pack_pos(input logic [PW-1:0] base);
    logic [OW-1:0] v;
    v = '0;
    for (int i = 0; i < ON; i++) v[i*PW +: PW] = base + PW'(i*3);
    return v;
  endfunction

  function automatic logic [LW-1:0] pack_len(input logic [PW-1:0] base);
    logic [LW-1:0] v;
    v = '0;
    for (int i = 0; i < ON; i++) v[i*BLW +: BLW] = BLW'(base + PW'(i));
    return v;
  endfunction

  task automatic cycles(input int n, input logic [9:0] yv);
    y = yv;
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic frame();
    cycles(50, 10'd480);
    cycles(20, 10'd100);
  endtask

  task automatic drive_data(input logic [PW-1:0] cx, input logic [PW-1:0] cy);
    upd_char_x  = cx;
    upd_char_y  = cy;
    upd_obs_x   = pack_pos(cx);
    upd_obs_y   = pack_pos(cy);
    upd_obs_len = pack_len(cx);
  endtask

  task automatic send(input logic [PW-1:0] cx, input logic [PW-1:0] cy);
    logic ok;
    ok = 1'b0;
    drive_data(cx, cy);
    upd_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (upd_ready) ok = 1'b1;
      @(negedge sys_clk);
    end
    upd_valid = 1'b0;
    chk("send_ready", 160'(ok), 160'd1);
  endtask

  task automatic chk_outputs(input string tag, input logic [PW-1:0] cx,
                             input logic [PW-1:0] cy, input logic [4:0] cam);
    chk({tag, "_char_x"}, 160'(char_abs_x), 160'(cx));
    chk({tag, "_char_y"}, 160'(char_abs_y), 160'(cy));
    chk({tag, "_cam"},    160'(camera_y),   160'(cam));
    chk({tag, "_obs_x"},  160'(obstacle_abs_pos_x),   160'(pack_pos(cx)));
    chk({tag, "_obs_y"},  160'(obstacle_abs_pos_y),   160'(pack_pos(cy)));
    chk({tag, "_obs_len"}, 160'(obstacle_block_width), 160'(pack_len(cx)));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_scalars"}, 160'({char_abs_x, char_abs_y, camera_y, commit_pulse, drop_cnt}), '0);
    chk({tag, "_obs"}, 160'({obstacle_abs_pos_x, obstacle_abs_pos_y, obstacle_block_width}), '0);
  endtask

  initial begin
    int p0, first_pulse, nhs, ncommit;
    logic [PW-1:0] dat, stg_y;

    tbl[0] = '{14'd11,  14'd479,   5'd0};
    tbl[1] = '{14'd22,  14'd480,   5'd1};
    tbl[2] = '{14'd33,  14'd16000, 5'd31};
    tbl[3] = '{14'd44,  14'd0,     5'd0};
    tbl[4] = '{14'd55,  14'd959,   5'd1};
    tbl[5] = '{14'd66,  14'd960,   5'd2};
    tbl[6] = '{14'd77,  14'd14879, 5'd30};
    tbl[7] = '{14'd88,  14'd14880, 5'd31};
    tbl[8] = '{14'd99,  14'd2400,  5'd5};
    tbl[9] = '{14'd123, 14'd16383, 5'd31};

    sys_rst = 1'b1; y = 10'd100; upd_valid = 1'b0; drive_data('0, '0);
    repeat (3) @(negedge sys_clk);
    chk("rst_ready", 160'(upd_ready), 160'd0);
    chk_zero("rst");
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("post_rst_ready", 160'(upd_ready), 160'd1);

    // First commit: exact latency with camera_y = 2 (T+5 after vb_q rises)
    send(14'd300, 14'd1000);
    cycles(3, 10'd100);
    chk("pre_vb_char_y", 160'(char_abs_y), 160'd0);
    chk("pend_ready", 160'(upd_ready), 160'd0);
    p0 = pulse_cnt;
    first_pulse = -1;
    y = 10'd480;
    for (int k = 1; k <= 10; k++) begin
      @(negedge sys_clk);
      if (commit_pulse && first_pulse < 0) begin
        first_pulse = k;
        chk_outputs("t1", 14'd300, 14'd1000, 5'd2);
        chk("t1_ready_back", 160'(upd_ready), 160'd1);
      end
    end
    chk("t1_pulse_at", 160'(first_pulse), 160'(6));
    chk("t1_pulse_count", 160'(pulse_cnt - p0), 160'd1);
    cycles(40, 10'd480);
    cycles(20, 10'd100);

    for (int i = 0; i < 10; i++) begin
      p0 = pulse_cnt;
      send(tbl[i].cx, tbl[i].cy);
      frame();
      chk($sformatf("tbl%0d_pulses", i), 160'(pulse_cnt - p0), 160'd1);
      chk_outputs($sformatf("tbl%0d", i), tbl[i].cx, tbl[i].cy, tbl[i].cam);
    end
    chk("tbl_drop", 160'(drop_cnt), 160'd0);

    p0 = pulse_cnt;
    repeat (3) frame();
    chk("drop3", 160'(drop_cnt), 160'd3);
    chk("drop3_pulses", 160'(pulse_cnt - p0), 160'd0);
    chk_outputs("drop3", tbl[9].cx, tbl[9].cy, tbl[9].cam);
    repeat (297) frame();
    chk("drop_sat", 160'(drop_cnt), 160'd255);

    // Continuous valid with changing data: one transfer per frame
    sys_rst = 1'b1;
    cycles(2, 10'd100);
    sys_rst = 1'b0;
    cycles(2, 10'd100);
    chk("rst2_drop", 160'(drop_cnt), 160'd0);
    nhs = 0; ncommit = 0; stg_y = '0;
    upd_valid = 1'b1;
    for (int c = 0; c < 3*70; c++) begin
      y = ((c % 70) < 20) ? 10'd100 : 10'd480;
      dat = PW'((c * 37) % 2400);
      drive_data(dat ^ 14'h155, dat);
      if (commit_pulse) begin
        ncommit++;
        chk("cont_char_y", 160'(char_abs_y), 160'(stg_y));
        chk("cont_cam", 160'(camera_y), 160'(stg_y / 14'd480));
      end
      if (upd_ready) begin
        nhs++;
        stg_y = dat;
      end
      @(negedge sys_clk);
    end
    upd_valid = 1'b0;
    chk("cont_hs", 160'(nhs), 160'd4);
    chk("cont_commits", 160'(ncommit), 160'd3);

    // Handshake in the cycle vb_q rises commits in the same vblank
    sys_rst = 1'b1;
    cycles(2, 10'd100);
    sys_rst = 1'b0;
    cycles(5, 10'd100);
    p0 = pulse_cnt;
    cycles(1, 10'd480);
    drive_data(14'd500, 14'd2000);
    upd_valid = 1'b1;
    chk("rise_ready", 160'(upd_ready), 160'd1);
    @(negedge sys_clk);
    upd_valid = 1'b0;
    cycles(48, 10'd480);
    cycles(20, 10'd100);
    chk("rise_pulses", 160'(pulse_cnt - p0), 160'd1);
    chk("rise_drop", 160'(drop_cnt), 160'd0);
    chk_outputs("rise", 14'd500, 14'd2000, 5'd4);

    // Reset in the middle of a long division
    send(14'd7, 14'd16000);
    p0 = pulse_cnt;
    cycles(5, 10'd480);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk_zero("divrst");
    chk("divrst_ready", 160'(upd_ready), 160'd0);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("divrst_ready_after", 160'(upd_ready), 160'd1);
    cycles(40, 10'd480);
    cycles(20, 10'd100);
    chk("divrst_pulses", 160'(pulse_cnt - p0), 160'd0);
    chk("divrst_char_y", 160'(char_abs_y), 160'd0);
    chk("divrst_drop", 160'(drop_cnt), 160'd1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
